// File: rtl/prefetch_queue.sv
// Instruction prefetch: fetches sequential 16-bit words from the bus, pairs them
// into 32-bit instructions and queues them for the decoder behind a small FIFO.
module prefetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       bus_req,
  output logic [ADDR_W-1:0]          fetch_address,
  input  logic [15:0]                bus_data,
  input  logic                       bus_ready,
  output logic [31:0]                ir,
  output logic                       ir_valid,
  input  logic                       ir_ack,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  // Bus side: a word is taken on any cycle where bus_req=1 and bus_ready=1.
  // Decoder side: the head is consumed on any cycle where ir_valid=1 and ir_ack=1.
  // flush overrides both handshakes in the cycle it is asserted.

  state_t             r_state;
  state_t             w_next_state;
  logic               r_bus_req;
  logic [ADDR_W-1:0]  r_addr;
  logic [15:0]        r_hi;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [31:0]        r_mem [DEPTH];

  logic w_accept;
  logic w_hi_done;
  logic w_push;
  logic w_pop;

  assign w_accept  = r_bus_req & bus_ready & ~flush;
  assign w_hi_done = w_accept & (r_state == REQ_HI);
  assign w_push    = w_accept & (r_state == REQ_LO);
  assign w_pop     = (r_count != '0) & ir_ack & ~flush;

  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (r_count < CNT_W'(DEPTH)) w_next_state = REQ_HI;
        REQ_HI:  if (w_hi_done) w_next_state = REQ_LO;
        REQ_LO: begin
          if (w_push) begin
            w_next_state = (w_count_next < CNT_W'(DEPTH)) ? REQ_HI : IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bus_req <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_bus_req <= (w_next_state != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= RESET_PC;
      r_hi     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_addr   <= flush_addr;
      r_hi     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_hi_done)          r_hi     <= bus_data;
      if (w_hi_done | w_push) r_addr   <= r_addr + ADDR_W'(1);
      if (w_push)             r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_hi, bus_data};
  end

  assign bus_req       = r_bus_req;
  assign fetch_address = r_addr;
  assign count         = r_count;
  assign ir_valid      = (r_count != '0);
  assign ir            = ir_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: bus responder and decoder driven from tasks, with a
// scoreboard queue of assembled instructions checked as the decoder consumes them.
module tb_prefetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              bus_req;
  logic [ADDR_W-1:0] fetch_address;
  logic [15:0]       bus_data;
  logic              bus_ready;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              ir_ack;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        dbg_state;

  prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .bus_req(bus_req), .fetch_address(fetch_address),
    .bus_data(bus_data), .bus_ready(bus_ready), .ir(ir), .ir_valid(ir_valid),
    .ir_ack(ir_ack), .flush(flush), .flush_addr(flush_addr), .count(count),
    .dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // scoreboard and bus model
  logic [31:0]       exp_q[$];
  logic [15:0]       m_hi;
  logic              m_phase;
  logic [ADDR_W-1:0] m_addr;

  task automatic model_reset();
    exp_q.delete();
    m_phase = 1'b0;
    m_hi    = '0;
    m_addr  = 16'h0000;
  endtask

  // One clock cycle; called and returns at a falling edge.
  task automatic step(input logic rdy, input logic [15:0] data, input logic ack,
                      input logic fl, input logic [ADDR_W-1:0] faddr);
    logic [31:0] exp;
    checks++;
    if (count !== CNT_W'(exp_q.size()))
      $display("FAIL count: got %0d expected %0d", count, exp_q.size());
    else passes++;
    checks++;
    if (ir_valid !== (exp_q.size() != 0))
      $display("FAIL ir_valid: got %b expected %b", ir_valid, exp_q.size() != 0);
    else passes++;
    if (rdy) begin
      checks++;
      if (bus_req !== 1'b1 || fetch_address !== m_addr)
        $display("FAIL bus_request: got req=%b addr=%h expected req=1 addr=%h",
                 bus_req, fetch_address, m_addr);
      else passes++;
    end
    bus_ready  = rdy;
    bus_data   = data;
    ir_ack     = ack;
    flush      = fl;
    flush_addr = faddr;
    if (fl) begin
      exp_q.delete();
      m_phase = 1'b0;
      m_addr  = faddr;
    end else begin
      if (ack && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (ir !== exp) $display("FAIL ir_pop: got %h expected %h", ir, exp);
        else passes++;
      end
      if (rdy) begin
        if (!m_phase) begin
          m_hi    = data;
          m_phase = 1'b1;
        end else begin
          exp_q.push_back({m_hi, data});
          m_phase = 1'b0;
        end
        m_addr = m_addr + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus_ready = 1'b0;
    ir_ack    = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, '0);
      n++;
    end
    checks++;
    if (bus_req !== 1'b1) $display("FAIL wait_req: bus_req=%b after %0d cycles", bus_req, n);
    else passes++;
  endtask

  task automatic fetch_word(input logic [15:0] data, input logic ack);
    wait_req();
    step(1'b1, data, ack, 1'b0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0; bus_ready = 1'b0; bus_data = '0; ir_ack = 1'b0;
    flush = 1'b0; flush_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || fetch_address !== 16'h0000 || ir !== 32'h0 ||
        ir_valid !== 1'b0 || count !== '0 || dbg_state !== 2'd0)
      $display("FAIL reset_state: req=%b addr=%h ir=%h v=%b cnt=%0d st=%0d expected 0/0000/0/0/0/0",
               bus_req, fetch_address, ir, ir_valid, count, dbg_state);
    else passes++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    fetch_word(16'h1234, 1'b0);
    fetch_word(16'h5678, 1'b0);
    checks++;
    if (ir !== 32'h12345678 || ir_valid !== 1'b1 || count !== CNT_W'(1) || fetch_address !== 16'h0002)
      $display("FAIL basic: ir=%h v=%b cnt=%0d addr=%h expected 12345678/1/1/0002",
               ir, ir_valid, count, fetch_address);
    else passes++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) fetch_word(16'($urandom_range(0, 16'hFFFF)), 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, '0);
    checks++;
    if (count !== CNT_W'(DEPTH) || bus_req !== 1'b0 || fetch_address !== 16'h0008)
      $display("FAIL fill_full: cnt=%0d req=%b addr=%h expected 4/0/0008", count, bus_req, fetch_address);
    else passes++;
    bus_ready = 1'b1; bus_data = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    bus_ready = 1'b0;
    checks++;
    if (count !== CNT_W'(DEPTH) || fetch_address !== 16'h0008)
      $display("FAIL ready_ignored: cnt=%0d addr=%h expected 4/0008", count, fetch_address);
    else passes++;
    step(1'b0, 16'h0, 1'b1, 1'b0, '0);
    step(1'b0, 16'h0, 1'b0, 1'b0, '0);
    checks++;
    if (bus_req !== 1'b1 || fetch_address !== 16'h0008 || count !== CNT_W'(3))
      $display("FAIL refetch: req=%b addr=%h cnt=%0d expected 1/0008/3", bus_req, fetch_address, count);
    else passes++;
  endtask

  task automatic test_back_to_back();
    step(1'b0, 16'h0, 1'b1, 1'b0, '0);
    fetch_word(16'h0A0A, 1'b0);
    fetch_word(16'h0B0B, 1'b1);
    checks++;
    if (count !== CNT_W'(2)) $display("FAIL concurrent_count: got %0d expected 2", count);
    else passes++;
    checks++;
    if (ir !== exp_q[0]) $display("FAIL concurrent_head: got %h expected %h", ir, exp_q[0]);
    else passes++;
  endtask

  task automatic test_flush();
    fetch_word(16'h1111, 1'b0);
    fetch_word(16'h2222, 1'b0);
    fetch_word(16'h3333, 1'b0);
    checks++;
    if (count !== CNT_W'(3) || dbg_state !== 2'd2)
      $display("FAIL flush_setup: cnt=%0d st=%0d expected 3/2", count, dbg_state);
    else passes++;
    step(1'b1, 16'h9999, 1'b0, 1'b1, 16'h0100);
    checks++;
    if (count !== '0 || ir_valid !== 1'b0 || ir !== 32'h0 || bus_req !== 1'b0 || fetch_address !== 16'h0100)
      $display("FAIL flush_clear: cnt=%0d v=%b ir=%h req=%b addr=%h expected 0/0/0/0/0100",
               count, ir_valid, ir, bus_req, fetch_address);
    else passes++;
    step(1'b0, 16'h0, 1'b0, 1'b0, '0);
    checks++;
    if (bus_req !== 1'b1 || fetch_address !== 16'h0100)
      $display("FAIL flush_refetch: req=%b addr=%h expected 1/0100", bus_req, fetch_address);
    else passes++;
    fetch_word(16'hCAFE, 1'b0);
    fetch_word(16'hF00D, 1'b0);
    checks++;
    if (ir !== 32'hCAFEF00D) $display("FAIL flush_fresh: got %h expected cafef00d", ir);
    else passes++;
  endtask

  task automatic test_wrap();
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
    fetch_word(16'hAAAA, 1'b0);
    fetch_word(16'hBBBB, 1'b0);
    checks++;
    if (ir !== 32'hAAAABBBB || fetch_address !== 16'h0001)
      $display("FAIL wrap: ir=%h addr=%h expected aaaabbbb/0001", ir, fetch_address);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic r, a, f;
      r = bus_req ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 1'($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 39) == 0);
      step(r, 16'($urandom_range(0, 16'hFFFF)), a, f, 16'($urandom_range(0, 16'hFFFF)));
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 16'h0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    fetch_word(16'h5555, 1'b0);
    fetch_word(16'h6666, 1'b0);
    wait_req();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || count !== '0 || ir_valid !== 1'b0)
      $display("FAIL async_reset: req=%b cnt=%0d v=%b expected 0/0/0", bus_req, count, ir_valid);
    else passes++;
    @(negedge clk);
    model_reset();
    bus_ready = 1'b1; bus_data = 16'hBEEF;
    @(posedge clk); @(negedge clk);
    bus_ready = 1'b0;
    reset = 1'b1;
    wait_req();
    checks++;
    if (fetch_address !== 16'h0000) $display("FAIL post_reset_addr: got %h expected 0000", fetch_address);
    else passes++;
    fetch_word(16'h7777, 1'b0);
    fetch_word(16'h8888, 1'b0);
    checks++;
    if (ir !== 32'h77778888) $display("FAIL post_reset_fetch: got %h expected 77778888", ir);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
